// File: rtl/parking_meter_core_pkg.sv
// rtl/parking_meter_core_pkg.sv - shared types, default tables and arbitration helper for the parking meter
//
// Package parking_meter_pkg:
//   bcd_state_e       : states of the sequential double-dabble converter
//   DEF_* constants   : default counter width and add/preset tables
//   lowest_set_index  : index of the lowest set bit of a request vector, -1 if none
package parking_meter_pkg;

    typedef enum logic [1:0] {
        BCD_IDLE  = 2'd0,
        BCD_SHIFT = 2'd1,
        BCD_DONE  = 2'd2
    } bcd_state_e;

    localparam int DEF_CNT_W   = 14;
    localparam int DEF_NUM_ADD = 4;
    localparam int DEF_NUM_PRE = 2;

    localparam logic [DEF_NUM_ADD*DEF_CNT_W-1:0] DEF_ADD_TABLE =
        {14'd300, 14'd180, 14'd60, 14'd10};
    localparam logic [DEF_NUM_PRE*DEF_CNT_W-1:0] DEF_PRE_TABLE =
        {14'd205, 14'd10};

    // Scans from the top down so the lowest set bit is the last one written.
    function automatic int lowest_set_index(input logic [31:0] req);
        int idx;
        idx = -1;
        for (int i = 31; i >= 0; i--) begin
            if (req[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/parking_meter_core_if.sv
// rtl/parking_meter_core_if.sv - request/display bundle between debouncer, meter core and 7-segment driver
//
// Signals:
//   add_req   [NUM_ADD]   one-cycle add-time pulses        (master -> slave)
//   pre_req   [NUM_PRE]   one-cycle preset pulses          (master -> slave)
//   pause                 hold countdown (PARKING_METER_PAUSE_EN builds only)
//   count     [CNT_W]     remaining seconds                (slave -> master)
//   bcd_value [4*DIGITS]  BCD image of count, digit 0 in LSBs
//   bcd_busy              conversion in progress
//   blank                 display blanked for flash
//   expired               count is zero
interface parking_meter_core_if #(
    parameter int CNT_W   = 14,
    parameter int DIGITS  = 4,
    parameter int NUM_ADD = 4,
    parameter int NUM_PRE = 2
) ();
    logic [NUM_ADD-1:0]  add_req;
    logic [NUM_PRE-1:0]  pre_req;
`ifdef PARKING_METER_PAUSE_EN
    logic                pause;
`endif
    logic [CNT_W-1:0]    count;
    logic [4*DIGITS-1:0] bcd_value;
    logic                bcd_busy;
    logic                blank;
    logic                expired;

`ifdef PARKING_METER_PAUSE_EN
    modport master (output add_req, pre_req, pause,
                    input  count, bcd_value, bcd_busy, blank, expired);
    modport slave  (input  add_req, pre_req, pause,
                    output count, bcd_value, bcd_busy, blank, expired);
`else
    modport master (output add_req, pre_req,
                    input  count, bcd_value, bcd_busy, blank, expired);
    modport slave  (input  add_req, pre_req,
                    output count, bcd_value, bcd_busy, blank, expired);
`endif

endinterface

// File: rtl/parking_meter_core_bcd_dd_seq.sv
// rtl/parking_meter_core_bcd_dd_seq.sv - sequential double-dabble binary-to-BCD converter with change tracking
//
// Ports:
//   clk     : system clock
//   reset   : asynchronous active-low reset
//   bin_i   : binary value to track; any change triggers a conversion
//   bcd_o   : last committed BCD image, updated atomically
//   busy_o  : high while shift iterations are running
//
// A change seen while a conversion is in flight is remembered in pending_q;
// the in-flight result still commits and a fresh conversion follows.
module bcd_dd_seq
    import parking_meter_pkg::*;
#(
    parameter int CNT_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CNT_W-1:0]    bin_i,
    output logic [4*DIGITS-1:0] bcd_o,
    output logic                busy_o
);
    localparam int SR_W = 4*DIGITS + CNT_W;
    localparam int IT_W = $clog2(CNT_W + 1);

    bcd_state_e          state_q, state_d;
    logic [CNT_W-1:0]    prev_q, prev_d;
    logic                pending_q, pending_d;
    logic [SR_W-1:0]     sr_q, sr_d;
    logic [IT_W-1:0]     iter_q, iter_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic                changed;
    logic                start;

    // One double-dabble iteration: add 3 to every digit >= 5, then shift left.
    function automatic logic [SR_W-1:0] dd_step(input logic [SR_W-1:0] s);
        logic [SR_W-1:0] t;
        t = s;
        for (int d = 0; d < DIGITS; d++) begin
            if (t[CNT_W + 4*d +: 4] >= 4'd5) begin
                t[CNT_W + 4*d +: 4] = t[CNT_W + 4*d +: 4] + 4'd3;
            end
        end
        return t << 1;
    endfunction

    // prev_q trails bin_i by one cycle, so a mismatch means bin_i just changed.
    assign changed = (bin_i != prev_q);
    assign start   = changed || pending_q;

    always_comb begin
        state_d   = state_q;
        prev_d    = bin_i;
        pending_d = pending_q;
        sr_d      = sr_q;
        iter_d    = iter_q;
        bcd_d     = bcd_q;
        case (state_q)
            BCD_IDLE: begin
                if (start) begin
                    sr_d      = {{(4*DIGITS){1'b0}}, bin_i};
                    iter_d    = '0;
                    pending_d = 1'b0;
                    state_d   = BCD_SHIFT;
                end
            end
            BCD_SHIFT: begin
                sr_d   = dd_step(sr_q);
                iter_d = iter_q + IT_W'(1);
                if (iter_q == IT_W'(CNT_W - 1)) begin
                    state_d = BCD_DONE;
                end
                if (changed) begin
                    pending_d = 1'b1;
                end
            end
            BCD_DONE: begin
                bcd_d   = sr_q[SR_W-1 -: 4*DIGITS];
                state_d = BCD_IDLE;
                if (changed) begin
                    pending_d = 1'b1;
                end
            end
            default: begin
                state_d = BCD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= BCD_IDLE;
            prev_q    <= '0;
            pending_q <= 1'b0;
            sr_q      <= '0;
            iter_q    <= '0;
            bcd_q     <= '0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            pending_q <= pending_d;
            sr_q      <= sr_d;
            iter_q    <= iter_d;
            bcd_q     <= bcd_d;
        end
    end

    assign bcd_o  = bcd_q;
    assign busy_o = (state_q == BCD_SHIFT);

endmodule

// File: rtl/parking_meter_core.sv
// rtl/parking_meter_core.sv - parking meter seconds counter with add/preset arbitration, BCD image and flash
//
// Ports:
//   clk    : system clock
//   reset  : asynchronous active-low reset
//   bus    : parking_meter_core_if.slave (add_req, pre_req, [pause] in;
//            count, bcd_value, bcd_busy, blank, expired out)
//
// Optional build macro PARKING_METER_PAUSE_EN adds bus.pause: while high the
// prescaler holds, no decrement happens and blank is forced low.
module parking_meter_core
    import parking_meter_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int DIGITS      = 4,
    parameter int MAX_COUNT   = 9999,
    parameter int TICK_CYCLES = 100_000_000,
    parameter int NUM_ADD     = DEF_NUM_ADD,
    parameter logic [NUM_ADD*CNT_W-1:0] ADD_TABLE = DEF_ADD_TABLE,
    parameter int NUM_PRE     = DEF_NUM_PRE,
    parameter logic [NUM_PRE*CNT_W-1:0] PRE_TABLE = DEF_PRE_TABLE,
    parameter int LOW_THRESH  = 200
) (
    input  logic                 clk,
    input  logic                 reset,
    parking_meter_core_if.slave  bus
);
    localparam int              PS_W    = $clog2(TICK_CYCLES);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_CYCLES - 1);
    localparam logic [PS_W-1:0] PS_HALF = PS_W'(TICK_CYCLES / 2);
    localparam logic [PS_W-1:0] PS_QTR  = PS_W'(TICK_CYCLES / 4);

    logic [PS_W-1:0]  presc_q, presc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             blank_q, blank_d;
    logic             paused;
    logic             tick;
    logic [CNT_W:0]   sum;
    int               pre_idx;
    int               add_idx;

`ifdef PARKING_METER_PAUSE_EN
    assign paused = bus.pause;
`else
    assign paused = 1'b0;
`endif

    assign tick = (presc_q == PS_LAST) && !paused;

    // Flash pattern evaluated on next-state values so the registered blank
    // lines up with the prescaler value it is visible alongside.
    function automatic logic flash(input logic [CNT_W-1:0] c, input logic [PS_W-1:0] p);
        logic b;
        b = 1'b0;
        if (c == '0) begin
            b = ((p % PS_HALF) >= PS_QTR);
        end else if (c < CNT_W'(LOW_THRESH)) begin
            b = (p >= PS_HALF);
        end
        return b;
    endfunction

    always_comb begin
        presc_d = presc_q;
        count_d = count_q;
        pre_idx = lowest_set_index(32'(bus.pre_req));
        add_idx = lowest_set_index(32'(bus.add_req));
        if (pre_idx < 0) pre_idx = 0;
        if (add_idx < 0) add_idx = 0;
        // Wide sum so a large increment saturates instead of wrapping.
        sum = {1'b0, count_q} + {1'b0, ADD_TABLE[add_idx*CNT_W +: CNT_W]};

        if (!paused) begin
            presc_d = (presc_q == PS_LAST) ? '0 : presc_q + PS_W'(1);
        end

        // A request in a tick cycle replaces the decrement rather than adding to it.
        if (|bus.pre_req) begin
            count_d = PRE_TABLE[pre_idx*CNT_W +: CNT_W];
        end else if (|bus.add_req) begin
            count_d = (sum > (CNT_W+1)'(MAX_COUNT)) ? CNT_W'(MAX_COUNT) : sum[CNT_W-1:0];
        end else if (tick && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end

        blank_d = paused ? 1'b0 : flash(count_d, presc_d);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
            count_q <= '0;
            blank_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            count_q <= count_d;
            blank_q <= blank_d;
        end
    end

    bcd_dd_seq #(
        .CNT_W  (CNT_W),
        .DIGITS (DIGITS)
    ) u_bcd (
        .clk    (clk),
        .reset  (reset),
        .bin_i  (count_q),
        .bcd_o  (bus.bcd_value),
        .busy_o (bus.bcd_busy)
    );

    assign bus.count   = count_q;
    assign bus.blank   = blank_q;
    assign bus.expired = (count_q == '0);

endmodule

// File: doc/parking_meter_core.md
Name: parking_meter_core

Overview:
Parametrised successor to the parking-meter counter/flash controller. Holds remaining time in seconds and counts it down on a prescaled tick. Accepts a configurable set of one-shot "add time" and "preset" requests, saturating at a ceiling. Produces an atomically updated multi-digit BCD image through a sequential double-dabble engine, plus a single display-blank flash signal. Sits between the button debouncer and the time-multiplexed 7-segment driver.

Parameters:
CNT_W, 14, width of the binary seconds counter.
DIGITS, 4, number of BCD digits output; MAX_COUNT must be at most 10^DIGITS-1.
MAX_COUNT, 9999, saturation ceiling for adds.
TICK_CYCLES, 100_000_000, clk cycles per second; must be divisible by 4 and at least 4.
NUM_ADD, 4, number of add-time request lines.
ADD_TABLE, {14'd300,14'd180,14'd60,14'd10}, packed NUM_ADD*CNT_W increments; entry i is bits [i*CNT_W +: CNT_W].
NUM_PRE, 2, number of preset request lines.
PRE_TABLE, {14'd205,14'd10}, packed NUM_PRE*CNT_W preset values.
LOW_THRESH, 200, slow flash when 0 < count < LOW_THRESH.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
add_req  input  NUM_ADD  one-cycle add pulses
pre_req  input  NUM_PRE  one-cycle preset pulses
count  output  CNT_W  remaining seconds, binary
bcd_value  output  4*DIGITS  BCD of count, digit 0 in the LSBs
bcd_busy  output  1  conversion in progress
blank  output  1  high means the display is blanked for flash
expired  output  1  high when count==0

Behaviour:
- Reset (reset==0, async): count=0, prescaler=0, bcd_value=0, bcd_busy=0, blank=0, expired=1, pending=0.
- Prescaler counts 0..TICK_CYCLES-1 and wraps. tick is asserted in the cycle where prescaler==TICK_CYCLES-1.
- Count update priority, one per cycle, registered:
  - Any pre_req bit high: count=PRE_TABLE[lowest set index].
  - Else any add_req bit high: count=min(count+ADD_TABLE[lowest set index], MAX_COUNT). Compute the sum at CNT_W+1 bits; no wrap.
  - Else tick and count>0: count=count-1.
  - At count==0, tick leaves count at 0 (no underflow).
- An add or preset coinciding with tick drops that decrement. The prescaler is never reset by requests.
- Multiple request bits in the same cycle: lowest index wins; the others are ignored.
- BCD FSM states:
  - IDLE: on a count change, or pending set, latch the count snapshot, clear pending, go to SHIFT.
  - SHIFT: CNT_W iterations of add-3-then-shift, one per cycle, with bcd_busy=1.
  - DONE: write bcd_value atomically in a single cycle, then return to IDLE.
  - Latency from the count change to the bcd_value update is CNT_W+2 cycles.
- Count changing during SHIFT sets pending. The in-flight result still commits, then a new conversion starts. bcd_value never shows a partial value.
- expired is combinational from the registered count (count==0).
- Flash, registered:
  - count==0: fast flash. blank=1 when (prescaler mod TICK_CYCLES/2) >= TICK_CYCLES/4.
  - 0<count<LOW_THRESH: slow flash. blank=1 when prescaler >= TICK_CYCLES/2.
  - Otherwise blank=0.

Optional Feature:
PARKING_METER_PAUSE_EN:
- Defined: adds input port pause (1 bit). While pause is high, the prescaler holds, there is no decrement, and blank is forced 0. Requests are still accepted.
- Undefined: no pause port; behaviour exactly as above.

Decomposition:
- Package parking_meter_pkg: BCD FSM state typedef (IDLE/SHIFT/DONE), default table constants, and the function lowest_set_index used for request arbitration.
- One sub-module, bcd_dd_seq: parametrised sequential double-dabble with start/busy/done and the pending logic. It is instantiated once; counter, prescaler and flash logic live in the top.

Test Plan:
Bench parameters: TICK_CYCLES=8, CNT_W=14, DIGITS=4.
- Reset mid-conversion, then release: count=0, bcd_value=16'h0000, bcd_busy=0. blank toggles with period 4 cycles (high in cycles 2-3 and 6-7 of each tick period).
- add_req=4'b0001 pulse: count=10 next cycle. bcd_value=16'h0010 exactly 16 cycles later. Slow flash: blank high at prescaler 4-7.
- pre_req=2'b10 (205) then 5 ticks: count 205→200 with blank=0. Next tick gives 199; slow flash starts.
- count=9900, add_req=4'b1000: count saturates at 9999, bcd_value=16'h9999. add_req=4'b1111 in one cycle: only +10 applied, still 9999.
- Add pulse in the same cycle as tick at count=50: count=110 (decrement dropped). Next tick gives 109.
- Two add pulses 3 cycles apart during a conversion: bcd_value goes only to the final correct value. No intermediate partial value appears; pending conversion observed.
